iob_timer_alarm_core: RTL and testbench

IOB_TIMER_ALARM_CORE -- requirements
Module: iob_timer_alarm_core

---
 rtl/iob_timer_alarm_core.sv | 135 +++++++++++++
 tb/tb_iob_timer_alarm_core.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_timer_alarm_core.sv
// Countdown timer with a 2*DATA_W-bit load register written in two halves,
// one-shot or auto-reload operation, a registered expiry pulse, a sticky
// interrupt flag and an on-demand snapshot of the running counter.
//
// Handshake: there is no valid/ready pair here. Every control input is a
// single-cycle pulse or level sampled on a rising clk_i edge where cke_i is
// high; with cke_i low every register holds and the inputs are ignored.
//
// Debug: the FSM has two states, and busy_o is a direct copy of the state
// register (1 = RUN, 0 = IDLE), so it serves as the state observation point.
module iob_timer_alarm_core #(
  parameter int DATA_W = 32
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  cke_i,
  input  logic                  load_low_wen_i,
  input  logic [DATA_W-1:0]     load_low_i,
  input  logic                  load_high_wen_i,
  input  logic [DATA_W-1:0]     load_high_i,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic                  periodic_i,
  input  logic                  irq_clr_i,
  input  logic                  rstrb_i,
  output logic [2*DATA_W-1:0]   remaining_o,
  output logic                  busy_o,
  output logic                  expire_o,
  output logic                  irq_o
);

  localparam int CNT_W = 2 * DATA_W;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   load_q, load_d;
  logic [CNT_W-1:0]   rem_q, rem_d;
  logic               expire_q, expire_d;
  logic               irq_q, irq_d;

  logic               load_nonzero;
  logic               start_ok;
  logic               cnt_is_one;
  logic               cnt_above_one;

  assign load_nonzero  = (load_q != '0);
  // A start with an empty load register is a no-op.
  assign start_ok      = start_i && load_nonzero;
  assign cnt_is_one    = (cnt_q == CNT_W'(1));
  assign cnt_above_one = (cnt_q > CNT_W'(1));

  // Load register: each half follows its own strobe; the counter only sees
  // load_q (the pre-write value) at the edge where start_i samples it.
  always_comb begin
    load_d = load_q;
    if (load_low_wen_i) begin
      load_d[DATA_W-1:0] = load_low_i;
    end
    if (load_high_wen_i) begin
      load_d[CNT_W-1:DATA_W] = load_high_i;
    end
  end

  // FSM next state and counter: stop beats start, start beats countdown.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    expire_d = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
    end else if (start_ok) begin
      cnt_d   = load_q;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (cnt_above_one) begin
        cnt_d = cnt_q - CNT_W'(1);
      end else if (cnt_is_one) begin
        expire_d = 1'b1;
        // Reload only if there is something to reload; a load register
        // cleared while running turns the last period into a one-shot.
        if (periodic_i && load_nonzero) begin
          cnt_d = load_q;
        end else begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end else begin
        // Counter already at zero while running (cannot be reached through
        // normal starts); park in IDLE rather than wrap around.
        state_d = IDLE;
      end
    end
  end

  // Sticky interrupt (set wins over clear) and counter snapshot.
  always_comb begin
    irq_d = irq_q;
    if (expire_d) begin
      irq_d = 1'b1;
    end else if (irq_clr_i) begin
      irq_d = 1'b0;
    end
    rem_d = rstrb_i ? cnt_q : rem_q;
  end

  // State register: async reset clears everything, cke_i gates all updates.
  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      load_q   <= '0;
      rem_q    <= '0;
      expire_q <= 1'b0;
      irq_q    <= 1'b0;
    end else if (cke_i) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      load_q   <= load_d;
      rem_q    <= rem_d;
      expire_q <= expire_d;
      irq_q    <= irq_d;
    end
  end

  assign remaining_o = rem_q;
  assign busy_o      = (state_q == RUN);
  assign expire_o    = expire_q;
  assign irq_o       = irq_q;

endmodule

// File: tb/tb_iob_timer_alarm_core.sv
// Bench for iob_timer_alarm_core (DATA_W = 4, 8-bit counter). Each scenario
// pushes its expected per-cycle {busy, expire, irq} triples into exp_q while
// building the stimulus, then pops one per clock edge and compares.
module tb_iob_timer_alarm_core;

  localparam int DATA_W = 4;
  localparam int CNT_W  = 2 * DATA_W;

  logic              clk_i;
  logic              arst_i;
  logic              cke_i;
  logic              load_low_wen_i;
  logic [DATA_W-1:0] load_low_i;
  logic              load_high_wen_i;
  logic [DATA_W-1:0] load_high_i;
  logic              start_i;
  logic              stop_i;
  logic              periodic_i;
  logic              irq_clr_i;
  logic              rstrb_i;
  logic [CNT_W-1:0]  remaining_o;
  logic              busy_o;
  logic              expire_o;
  logic              irq_o;

  logic [2:0]        exp_q[$];
  logic [2:0]        exp_v;
  logic [2:0]        got_v;
  int                n_checks;
  int                n_errors;

  iob_timer_alarm_core #(.DATA_W(DATA_W)) dut (
    .clk_i           (clk_i),
    .arst_i          (arst_i),
    .cke_i           (cke_i),
    .load_low_wen_i  (load_low_wen_i),
    .load_low_i      (load_low_i),
    .load_high_wen_i (load_high_wen_i),
    .load_high_i     (load_high_i),
    .start_i         (start_i),
    .stop_i          (stop_i),
    .periodic_i      (periodic_i),
    .irq_clr_i       (irq_clr_i),
    .rstrb_i         (rstrb_i),
    .remaining_o     (remaining_o),
    .busy_o          (busy_o),
    .expire_o        (expire_o),
    .irq_o           (irq_o)
  );

  // Clock
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // ---------------- driver tasks ----------------
  // One rising edge; outputs are settled 1 time unit later and pulses drop.
  task automatic edge_step();
    @(posedge clk_i);
    #1;
    start_i         = 1'b0;
    stop_i          = 1'b0;
    irq_clr_i       = 1'b0;
    rstrb_i         = 1'b0;
    load_low_wen_i  = 1'b0;
    load_high_wen_i = 1'b0;
  endtask

  task automatic drive_load(input logic [CNT_W-1:0] v);
    load_low_wen_i  = 1'b1;
    load_high_wen_i = 1'b1;
    load_low_i      = v[DATA_W-1:0];
    load_high_i     = v[CNT_W-1:DATA_W];
    edge_step();
  endtask

  task automatic clear_irq();
    irq_clr_i = 1'b1;
    edge_step();
  endtask

  task automatic push_exp(input logic b, input logic e, input logic i);
    exp_q.push_back({b, e, i});
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    arst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    n_checks++;
    if ({busy_o, expire_o, irq_o} !== 3'b000) begin
      n_errors++;
      $display("FAIL reset_flags got %b want 000", {busy_o, expire_o, irq_o});
    end
    n_checks++;
    if (remaining_o !== '0) begin
      n_errors++;
      $display("FAIL reset_remaining got %0d want 0", remaining_o);
    end
    arst_i = 1'b0;
    edge_step();
  endtask

  task automatic test_oneshot();
    drive_load(8'd5);
    for (int k = 0; k < 8; k++) push_exp(k <= 4, k == 5, k >= 5);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) start_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL oneshot k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    rstrb_i = 1'b1;
    edge_step();
    n_checks++;
    if (remaining_o !== 8'd0) begin
      n_errors++;
      $display("FAIL oneshot_snapshot got %0d want 0", remaining_o);
    end
    clear_irq();
    n_checks++;
    if (irq_o !== 1'b0) begin
      n_errors++;
      $display("FAIL irq_clear got %b want 0", irq_o);
    end
  endtask

  task automatic test_periodic();
    drive_load(8'd3);
    periodic_i = 1'b1;
    for (int k = 0; k <= 10; k++)
      push_exp(1'b1, (k == 3) || (k == 6) || (k == 9), (k == 3) || (k >= 6));
    for (int k = 0; k <= 10; k++) begin
      if (k == 0) start_i = 1'b1;
      if (k == 4) irq_clr_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL periodic k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    stop_i     = 1'b1;
    periodic_i = 1'b0;
    edge_step();
    clear_irq();
  endtask

  task automatic test_boundaries();
    // Load 0 + start: nothing happens.
    drive_load(8'd0);
    for (int k = 0; k < 3; k++) push_exp(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k == 0) start_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL zero_load k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    // Load 1 periodic: expiry every cycle.
    drive_load(8'd1);
    periodic_i = 1'b1;
    for (int k = 0; k < 6; k++) push_exp(1'b1, k >= 1, k >= 1);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) start_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL load1_periodic k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    stop_i     = 1'b1;
    periodic_i = 1'b0;
    edge_step();
    clear_irq();
    // High half 1, low half 0 -> 16 cycles.
    load_high_wen_i = 1'b1;
    load_high_i     = 4'd1;
    edge_step();
    load_low_wen_i  = 1'b1;
    load_low_i      = 4'd0;
    edge_step();
    for (int k = 0; k < 19; k++) push_exp(k <= 15, k == 16, k >= 16);
    for (int k = 0; k < 19; k++) begin
      if (k == 0) start_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL load16 k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    clear_irq();
  endtask

  task automatic test_priority();
    // Stop on the counter==1 cycle: no expiry, counter holds at 1.
    drive_load(8'd3);
    for (int k = 0; k < 6; k++) push_exp(k <= 2, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) start_i = 1'b1;
      if (k == 3) stop_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL stop_at_one k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    rstrb_i = 1'b1;
    edge_step();
    n_checks++;
    if (remaining_o !== 8'd1) begin
      n_errors++;
      $display("FAIL stop_snapshot got %0d want 1", remaining_o);
    end
    // Start with a same-edge write of 9 over 4: the count uses 4.
    drive_load(8'd4);
    for (int k = 0; k < 6; k++) push_exp(k <= 3, k == 4, k >= 4);
    for (int k = 0; k < 6; k++) begin
      if (k == 0) begin
        start_i        = 1'b1;
        load_low_wen_i = 1'b1;
        load_low_i     = 4'd9;
      end
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL start_vs_write k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    clear_irq();
  endtask

  task automatic test_back_to_back();
    // Load register now holds 9; restart at k=3 reloads 9 -> expiry at k=12.
    for (int k = 0; k < 14; k++) push_exp(k <= 11, k == 12, k >= 12);
    for (int k = 0; k < 14; k++) begin
      if (k == 0 || k == 3) start_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL restart k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    clear_irq();
  endtask

  task automatic test_cke();
    drive_load(8'd5);
    for (int k = 0; k < 10; k++) push_exp(k <= 7, k == 8, k >= 8);
    for (int k = 0; k < 10; k++) begin
      if (k == 0) start_i = 1'b1;
      cke_i = !(k >= 2 && k <= 4);
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL cke_hold k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
    cke_i = 1'b1;
    clear_irq();
  endtask

  task automatic test_async_reset();
    drive_load(8'd5);
    start_i = 1'b1;
    edge_step();
    rstrb_i = 1'b1;
    edge_step();
    n_checks++;
    if (remaining_o !== 8'd5) begin
      n_errors++;
      $display("FAIL pre_reset_snapshot got %0d want 5", remaining_o);
    end
    // Assert reset between edges with cke low: outputs must clear at once.
    #2;
    cke_i  = 1'b0;
    arst_i = 1'b1;
    #1;
    n_checks++;
    if ({busy_o, expire_o, irq_o} !== 3'b000 || remaining_o !== '0) begin
      n_errors++;
      $display("FAIL async_reset got %b/%0d want 000/0",
               {busy_o, expire_o, irq_o}, remaining_o);
    end
    edge_step();
    arst_i = 1'b0;
    cke_i  = 1'b1;
    // No expiry afterwards; start is ignored because the load register is 0.
    for (int k = 0; k < 8; k++) push_exp(1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) begin
      if (k == 0) start_i = 1'b1;
      edge_step();
      exp_v = exp_q.pop_front();
      got_v = {busy_o, expire_o, irq_o};
      n_checks++;
      if (got_v !== exp_v) begin
        n_errors++;
        $display("FAIL post_reset k=%0d got %b want %b", k, got_v, exp_v);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_checks        = 0;
    n_errors        = 0;
    arst_i          = 1'b1;
    cke_i           = 1'b1;
    load_low_wen_i  = 1'b0;
    load_low_i      = '0;
    load_high_wen_i = 1'b0;
    load_high_i     = '0;
    start_i         = 1'b0;
    stop_i          = 1'b0;
    periodic_i      = 1'b0;
    irq_clr_i       = 1'b0;
    rstrb_i         = 1'b0;

    test_reset();
    test_oneshot();
    test_periodic();
    test_boundaries();
    test_priority();
    test_back_to_back();
    test_cke();
    test_async_reset();

    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_leftover got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
